pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush controller for the dual-issue 5-stage pipeline. It consumes stall requests from the decode hazard unit (load-use), icache and dcache. It also consumes redirect requests from EX (branch mispredict) and from the trap unit. It produces per-stage hold and bubble controls for PC, IFID, IDEX, EXMem and MemWb, plus the PC redirect. A redirect that cannot be taken because fetch is busy is buffered and issued later. Stall and flush event counters are kept for performance monitoring.

Parameters:
PC_WIDTH, 32, width of redirect PCs
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
DecodeHazard_StallReq  in  1  load-use hazard in decode
Icache_StallReq  in  1  fetch not ready (miss outstanding)
Dcache_StallReq  in  1  MEM-stage miss outstanding
EX_BranchMiss  in  1  mispredict resolved in EX
EX_RedirectPc  in  PC_WIDTH  correct target
Trap_Req  in  1  exception/interrupt taken at MEM
Trap_Pc  in  PC_WIDTH  trap vector
PC_Stall, IFID_Stall, IDEX_Stall, EXMem_Stall, MemWb_Stall  out  1 each  hold stage register
IFID_Flush, IDEX_Flush, EXMem_Flush, MemWb_Flush  out  1 each  load bubble (both issue slots) into stage register
PC_RedirectEn  out  1  load PC_RedirectPc into PC this cycle
PC_RedirectPc  out  PC_WIDTH  redirect target
Ctrl_StallCnt  out  CNT_WIDTH  cycles with PC_Stall=1
Ctrl_FlushCnt  out  CNT_WIDTH  redirects issued

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. On reset:
  - all Stall/Flush outputs are 0 and PC_RedirectEn=0.
  - PC_RedirectPc=0, counters=0, state=RUN, pending register cleared.
- Per-cycle priority (combinational outputs), evaluated highest first:
  1. Trap_Req: flush IFID, IDEX, EXMem; no stalls; redirect to Trap_Pc. Overrides every other request, including Dcache_StallReq (the trap kills the faulting access).
  2. Dcache_StallReq: stall PC, IFID, IDEX, EXMem; MemWb_Flush=1. EX_BranchMiss is ignored this cycle; EX is frozen, so it is re-presented when the stall releases.
  3. EX_BranchMiss: flush IFID, IDEX; redirect to EX_RedirectPc. DecodeHazard_StallReq is masked because the decode instruction is wrong-path.
  4. DecodeHazard_StallReq: stall PC, IFID; IDEX_Flush=1. Exactly one bubble per assertion cycle.
  5. Icache_StallReq alone: stall PC; IFID_Flush=1.
- Redirect path (2-state FSM, RUN / REDIR):
  - RUN, redirect selected, Icache_StallReq=0: PC_RedirectEn=1 the same cycle; PC_RedirectPc = target; stay in RUN.
  - RUN, redirect selected, Icache_StallReq=1: capture the target into the pending register; go to REDIR; PC_RedirectEn=0.
  - REDIR:
    - PC_Stall=1 and IFID_Flush=1 every cycle, so no wrong-path fetch enters decode.
    - When Icache_StallReq=0, PC_RedirectEn=1 with the pending target; return to RUN.
    - A Trap_Req in REDIR overwrites the pending target with Trap_Pc (a later trap wins). An EX_BranchMiss in REDIR is ignored, because EX was already flushed.
  - A trap and a pending release in the same cycle: the trap target is issued.
- PC_RedirectPc: holds its last value when PC_RedirectEn=0.
- Flush vs. stall on the same register: flush wins (bubble loaded).
- Counters:
  - Ctrl_StallCnt increments on each cycle with PC_Stall=1.
  - Ctrl_FlushCnt increments on each cycle with PC_RedirectEn=1.
  - Both saturate at all-ones; no wrap-around.
- Reset asserted mid-REDIR: the pending redirect is discarded; state returns to RUN the next cycle.
- No internal latency on stall/flush: outputs are pure functions of the current inputs and state.

Test Plan:
- Load-use: DecodeHazard_StallReq=1 for 1 cycle -> PC_Stall=IFID_Stall=1, IDEX_Flush=1 that cycle only; Ctrl_StallCnt 0→1.
- Branch miss with no icache stall: EX_BranchMiss=1, EX_RedirectPc=0x0000_1040, DecodeHazard_StallReq=1 -> IFID_Flush=IDEX_Flush=1, PC_RedirectEn=1, PC_RedirectPc=0x1040, PC_Stall=0; Ctrl_FlushCnt=1.
- Buffered redirect: EX_BranchMiss with target 0x2000 while Icache_StallReq=1 for 3 cycles -> state REDIR, PC_Stall=IFID_Flush=1 for 3 cycles, PC_RedirectEn=1 with 0x2000 in the cycle Icache_StallReq drops, exactly once.
- Dcache miss masks branch: Dcache_StallReq=1 for 4 cycles with EX_BranchMiss=1 -> PC/IFID/IDEX/EXMem stalled, MemWb_Flush=1, no redirect. In the cycle after release, the redirect fires.
- Trap override: Trap_Req=1 (Trap_Pc=0x8000_0000) together with Dcache_StallReq=1 and EX_BranchMiss=1 -> IFID/IDEX/EXMem_Flush=1, no stalls, PC_RedirectPc=0x8000_0000. While in REDIR with pending 0x2000, a trap replaces the pending target with 0x8000_0000.
- Saturation/reset: force Ctrl_StallCnt to 0xFFFF and keep stalling -> stays 0xFFFF. Assert rst in REDIR -> next cycle all outputs 0, counters 0, no redirect issued after release.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the hazard sources and the pipeline stall/flush controller.
// The master side raises requests; the slave side (pipe_ctrl) drives the stage controls.
interface pipe_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 DecodeHazard_StallReq;
  logic                 Icache_StallReq;
  logic                 Dcache_StallReq;
  logic                 EX_BranchMiss;
  logic [PC_WIDTH-1:0]  EX_RedirectPc;
  logic                 Trap_Req;
  logic [PC_WIDTH-1:0]  Trap_Pc;

  logic                 PC_Stall, IFID_Stall, IDEX_Stall, EXMem_Stall, MemWb_Stall;
  logic                 IFID_Flush, IDEX_Flush, EXMem_Flush, MemWb_Flush;
  logic                 PC_RedirectEn;
  logic [PC_WIDTH-1:0]  PC_RedirectPc;
  logic [CNT_WIDTH-1:0] Ctrl_StallCnt;
  logic [CNT_WIDTH-1:0] Ctrl_FlushCnt;

  modport master (
    output DecodeHazard_StallReq, Icache_StallReq, Dcache_StallReq,
           EX_BranchMiss, EX_RedirectPc, Trap_Req, Trap_Pc,
    input  PC_Stall, IFID_Stall, IDEX_Stall, EXMem_Stall, MemWb_Stall,
           IFID_Flush, IDEX_Flush, EXMem_Flush, MemWb_Flush,
           PC_RedirectEn, PC_RedirectPc, Ctrl_StallCnt, Ctrl_FlushCnt
  );

  modport slave (
    input  DecodeHazard_StallReq, Icache_StallReq, Dcache_StallReq,
           EX_BranchMiss, EX_RedirectPc, Trap_Req, Trap_Pc,
    output PC_Stall, IFID_Stall, IDEX_Stall, EXMem_Stall, MemWb_Stall,
           IFID_Flush, IDEX_Flush, EXMem_Flush, MemWb_Flush,
           PC_RedirectEn, PC_RedirectPc, Ctrl_StallCnt, Ctrl_FlushCnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the dual-issue 5-stage pipeline: prioritises hazards, issues or
// buffers PC redirects while fetch is busy, and keeps saturating stall/redirect counters.
module pipe_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [PC_WIDTH-1:0]  pendPc;
  logic [PC_WIDTH-1:0]  lastPc;
  logic [CNT_WIDTH-1:0] stallCnt;
  logic [CNT_WIDTH-1:0] flushCnt;

  logic                inRedir, branchEff, redirReq, defer, issue;
  logic [PC_WIDTH-1:0] issuePc;
  logic                pcS, ifidS, idexS, exmemS, memwbS;
  logic                ifidF, idexF, exmemF, memwbF;

  // Redirect selection: a branch miss only counts in RUN and when MEM is not frozen.
  always_comb begin
    inRedir   = (state == REDIR);
    branchEff = !inRedir && bus.EX_BranchMiss && !bus.Dcache_StallReq;
    redirReq  = bus.Trap_Req || branchEff;
    issue     = 1'b0;
    defer     = 1'b0;
    issuePc   = lastPc;
    if (inRedir) begin
      issue   = !bus.Icache_StallReq;
      issuePc = bus.Trap_Req ? bus.Trap_Pc : pendPc;
    end else if (redirReq) begin
      issue   = !bus.Icache_StallReq;
      defer   = bus.Icache_StallReq;
      issuePc = bus.Trap_Req ? bus.Trap_Pc : bus.EX_RedirectPc;
    end
    if (rst) begin
      issue = 1'b0;
      defer = 1'b0;
    end
  end

  always_comb begin
    pcS    = 1'b0;
    ifidS  = 1'b0;
    idexS  = 1'b0;
    exmemS = 1'b0;
    memwbS = 1'b0;
    ifidF  = 1'b0;
    idexF  = 1'b0;
    exmemF = 1'b0;
    memwbF = 1'b0;
    if (bus.Trap_Req) begin
      ifidF  = 1'b1;
      idexF  = 1'b1;
      exmemF = 1'b1;
    end else if (bus.Dcache_StallReq) begin
      pcS    = 1'b1;
      ifidS  = 1'b1;
      idexS  = 1'b1;
      exmemS = 1'b1;
      memwbF = 1'b1;
    end else if (branchEff) begin
      ifidF  = 1'b1;
      idexF  = 1'b1;
    end else if (bus.DecodeHazard_StallReq) begin
      pcS    = 1'b1;
      ifidS  = 1'b1;
      idexF  = 1'b1;
    end else if (bus.Icache_StallReq) begin
      pcS    = 1'b1;
      ifidF  = 1'b1;
    end
    // While a redirect is outstanding, hold PC and keep wrong-path fetches out of decode.
    if (inRedir) begin
      pcS   = 1'b1;
      ifidF = 1'b1;
    end
    if (defer) pcS = 1'b1;
    // A redirect loads the PC, which overrides any hold on it.
    if (issue) pcS = 1'b0;
    // Flush beats stall on the same register.
    ifidS  = ifidS  && !ifidF;
    idexS  = idexS  && !idexF;
    exmemS = exmemS && !exmemF;
    memwbS = memwbS && !memwbF;
    if (rst) begin
      pcS    = 1'b0;
      ifidS  = 1'b0;
      idexS  = 1'b0;
      exmemS = 1'b0;
      memwbS = 1'b0;
      ifidF  = 1'b0;
      idexF  = 1'b0;
      exmemF = 1'b0;
      memwbF = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pendPc   <= '0;
      lastPc   <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (defer) begin
        state  <= REDIR;
        pendPc <= issuePc;
      end else if (inRedir && issue) begin
        state  <= RUN;
      end else if (inRedir && bus.Trap_Req) begin
        pendPc <= bus.Trap_Pc;
      end
      if (issue) lastPc <= issuePc;
      if (pcS && !(&stallCnt)) stallCnt <= stallCnt + CNT_ONE;
      if (issue && !(&flushCnt)) flushCnt <= flushCnt + CNT_ONE;
    end
  end

  assign bus.PC_Stall      = pcS;
  assign bus.IFID_Stall    = ifidS;
  assign bus.IDEX_Stall    = idexS;
  assign bus.EXMem_Stall   = exmemS;
  assign bus.MemWb_Stall   = memwbS;
  assign bus.IFID_Flush    = ifidF;
  assign bus.IDEX_Flush    = idexF;
  assign bus.EXMem_Flush   = exmemF;
  assign bus.MemWb_Flush   = memwbF;
  assign bus.PC_RedirectEn = issue;
  assign bus.PC_RedirectPc = rst ? '0 : (issue ? issuePc : lastPc);
  assign bus.Ctrl_StallCnt = stallCnt;
  assign bus.Ctrl_FlushCnt = flushCnt;
endmodule
